// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: datapath width, opcodes and sequencer states.
package alu_pkg;

  localparam int unsigned W = 16;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_ASSIGN = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_DIV    = 3'b101;
  localparam logic [2:0] OP_SHL    = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } seq_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the one
// that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = (&valid) ? ~last_grant : valid[1];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Arbitrates two requesters onto the shared ALU, holds DIV for DIV_CYCLES cycles and
// returns the captured result on a registered, ID-tagged response bus.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [2:0]   req0_op,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out1,
  input  logic [W-1:0] alu_out2,
  input  logic         alu_zero,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_out1,
  output logic [W-1:0] rsp_out2,
  output logic         rsp_zero,
  output logic         busy
);

  localparam int unsigned     CntW    = $clog2(DIV_CYCLES + 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  seq_state_t      state_q, state_d;
  logic            last_grant_q;
  logic            grant_id_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      alu_op_q;
  logic [W-1:0]    alu_a_q, alu_b_q;
  logic            rsp_valid_q, rsp_id_q, rsp_zero_q;
  logic [W-1:0]    rsp_out1_q, rsp_out2_q;

  logic            grant_id, grant_valid, accept;
  logic [2:0]      sel_op;
  logic [W-1:0]    sel_a, sel_b;

  rr_arbiter2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant_q),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is masked during reset so no transfer is seen by a requester.
        if (grant_valid && !reset) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      cnt_q        <= '0;
      alu_op_q     <= OP_NOP;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_out1_q   <= '0;
      rsp_out2_q   <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      if (accept) begin
        alu_op_q     <= sel_op;
        alu_a_q      <= sel_a;
        alu_b_q      <= sel_b;
        grant_id_q   <= grant_id;
        last_grant_q <= grant_id;
        cnt_q        <= (sel_op == OP_DIV) ? DivLoad : '0;
      end
      if (state_q == EXEC) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CntW'(1);
        end else begin
          // Final EXEC edge: the ALU outputs have had the full path budget to settle.
          rsp_out1_q  <= alu_out1;
          rsp_out2_q  <= alu_out2;
          rsp_zero_q  <= alu_zero;
          rsp_id_q    <= grant_id_q;
          rsp_valid_q <= 1'b1;
          alu_op_q    <= OP_NOP;
        end
      end
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out1  = rsp_out1_q;
  assign rsp_out2  = rsp_out2_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural combinational ALU.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] alu_a, alu_b, alu_out1, alu_out2;
  logic         alu_zero;
  logic         rsp_valid, rsp_id, rsp_zero, busy;
  logic [W-1:0] rsp_out1, rsp_out2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DIV_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out1   (alu_out1),
    .alu_out2   (alu_out2),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_out1   (rsp_out1),
    .rsp_out2   (rsp_out2),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  // Reference ALU; its flag is high when out1 is nonzero.
  always_comb begin
    alu_out1 = '0;
    alu_out2 = '0;
    case (alu_op)
      OP_ASSIGN: alu_out1 = alu_a;
      OP_ADD:    alu_out1 = alu_a + alu_b;
      OP_SUB:    alu_out1 = alu_a - alu_b;
      OP_MUL:    {alu_out2, alu_out1} = alu_a * alu_b;
      OP_DIV: begin
        alu_out1 = (alu_b != 0) ? alu_a / alu_b : '0;
        alu_out2 = (alu_b != 0) ? alu_a % alu_b : '0;
      end
      OP_SHL:    alu_out1 = alu_a << alu_b[3:0];
      default: ;
    endcase
    alu_zero = (alu_out1 != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual still running, required finished");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge of the cycle after the handshake.
  task automatic issue(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL issue_ready: got %b required %b", {req1_ready, req0_ready},
               id ? 2'b10 : 2'b01);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({busy, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero});
    end
    vectors++;
    if ({alu_op, alu_a, alu_b, rsp_out1, rsp_out2} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got op=%0d a=%0d b=%0d o1=%0d o2=%0d required all 0",
               alu_op, alu_a, alu_b, rsp_out1, rsp_out2);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    issue(1'b0, OP_ADD, 16'd3, 16'd5);
    vectors++;
    if (alu_op !== OP_ADD || alu_a !== 16'd3 || alu_b !== 16'd5 || busy !== 1'b1
        || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_exec: got op=%0d a=%0d b=%0d busy=%b rv=%b required 2 3 5 1 0",
               alu_op, alu_a, alu_b, busy, rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out1 !== 16'd8 || rsp_zero !== 1'b1
        || alu_op !== OP_NOP || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL add_rsp: got rv=%b id=%b o1=%0d z=%b op=%0d busy=%b required 1 0 8 1 0 1",
               rsp_valid, rsp_id, rsp_out1, rsp_zero, alu_op, busy);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_out1 !== 16'd8) begin
      miscompares++;
      $display("FAIL add_after: got rv=%b busy=%b o1=%0d required 0 0 8",
               rsp_valid, busy, rsp_out1);
    end
  endtask

  task automatic test_div();
    issue(1'b1, OP_DIV, 16'd100, 16'd7);
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (alu_op !== OP_DIV || busy !== 1'b1 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL div_exec%0d: got op=%0d busy=%b rv=%b required 5 1 0",
                 i, alu_op, busy, rsp_valid);
      end
      @(negedge clk);
    end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out1 !== 16'd14 || rsp_out2 !== 16'd2
        || rsp_zero !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL div_rsp: got rv=%b id=%b o1=%0d o2=%0d z=%b busy=%b required 1 1 14 2 1 1",
               rsp_valid, rsp_id, rsp_out1, rsp_out2, rsp_zero, busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL div_after: got busy=%b rv=%b required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 16'd1; req1_b = 16'd1;
    #1;
    for (int g = 0; g < 4; g++) begin
      logic exp_id;
      exp_id = logic'(g % 2);
      vectors++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL cont_grant%0d: got %b required %b", g, {req1_ready, req0_ready},
                 exp_id ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        miscompares++;
        $display("FAIL cont_exec%0d: got ready %b required 00", g, {req1_ready, req0_ready});
      end
      @(negedge clk);
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== exp_id
          || rsp_out1 !== 16'd2) begin
        miscompares++;
        $display("FAIL cont_rsp%0d: got ready=%b rv=%b id=%b o1=%0d required 00 1 %b 2",
                 g, {req1_ready, req0_ready}, rsp_valid, rsp_id, rsp_out1, exp_id);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_zero_flag();
    issue(1'b0, OP_SUB, 16'd5, 16'd5);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_out1 !== 16'd0 || rsp_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_zero: got rv=%b o1=%0d z=%b required 1 0 0",
               rsp_valid, rsp_out1, rsp_zero);
    end
    @(negedge clk);
    issue(1'b1, OP_SHL, 16'd1, 16'd4);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out1 !== 16'd16 || rsp_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL shl: got rv=%b id=%b o1=%0d z=%b required 1 1 16 1",
               rsp_valid, rsp_id, rsp_out1, rsp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_div();
    issue(1'b0, OP_DIV, 16'd100, 16'd7);
    @(negedge clk);
    vectors++;
    if (alu_op !== OP_DIV || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_exec2: got op=%0d busy=%b required 5 1", alu_op, busy);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero} !== 6'b0
        || {alu_op, alu_a, alu_b, rsp_out1, rsp_out2} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b rv=%b op=%0d a=%0d b=%0d o1=%0d o2=%0d required all 0",
               busy, rsp_valid, alu_op, alu_a, alu_b, rsp_out1, rsp_out2);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_norsp%0d: got rv=%b busy=%b required 0 0", i, rsp_valid, busy);
      end
    end
    issue(1'b0, OP_ADD, 16'd2, 16'd3);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out1 !== 16'd5) begin
      miscompares++;
      $display("FAIL mid_newadd: got rv=%b id=%b o1=%0d required 1 0 5",
               rsp_valid, rsp_id, rsp_out1);
    end
    @(negedge clk);
  endtask

  task automatic test_nop();
    issue(1'b0, OP_NOP, 16'd9, 16'd9);
    vectors++;
    if (busy !== 1'b1 || alu_op !== OP_NOP || alu_a !== 16'd9) begin
      miscompares++;
      $display("FAIL nop_exec: got busy=%b op=%0d a=%0d required 1 0 9", busy, alu_op, alu_a);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_out1 !== 16'd0 || rsp_out2 !== 16'd0 || rsp_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL nop_rsp: got rv=%b o1=%0d o2=%0d z=%b required 1 0 0 0",
               rsp_valid, rsp_out1, rsp_out2, rsp_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // MUL then opcode 111 from requester 1; the second accept lands three cycles later.
    issue(1'b1, OP_MUL, 16'h0100, 16'h0300);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_out1 !== 16'h0000 || rsp_out2 !== 16'h0003
        || rsp_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_rsp: got rv=%b o1=%h o2=%h z=%b required 1 0000 0003 0",
               rsp_valid, rsp_out1, rsp_out2, rsp_zero);
    end
    @(negedge clk);
    issue(1'b1, 3'b111, 16'd4, 16'd4);
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out1 !== 16'd0 || rsp_out2 !== 16'd0) begin
      miscompares++;
      $display("FAIL op7_rsp: got rv=%b id=%b o1=%0d o2=%0d required 1 1 0 0",
               rsp_valid, rsp_id, rsp_out1, rsp_out2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_contention();
    test_zero_flag();
    test_reset_mid_div();
    test_nop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
